// File: rtl/fproc_arbiter.sv
// Round-robin arbiter that shares one fproc port between N_CORES cores.
// Requests are latched per core, served one at a time, and a watchdog bounds the wait for fproc.
module fproc_arbiter #(
  parameter int N_CORES        = 4,
  parameter int ID_WIDTH       = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_CORES-1:0]           core_req,
  input  logic [N_CORES*ID_WIDTH-1:0]  core_id,
  output logic [N_CORES-1:0]           core_ready,
  output logic [DATA_WIDTH-1:0]        core_data,
  output logic                         fproc_req,
  output logic [ID_WIDTH-1:0]          fproc_id,
  output logic [$clog2(N_CORES)-1:0]   fproc_core,
  input  logic                         fproc_ready,
  input  logic [DATA_WIDTH-1:0]        fproc_data,
  output logic                         busy,
  output logic                         timeout_err
);

  localparam int CORE_W  = $clog2(N_CORES);
  localparam int TIMER_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST =
    (TIMEOUT_CYCLES > 0) ? TIMER_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                       state_reg;
  logic [N_CORES-1:0]           pending_reg;
  logic [N_CORES*ID_WIDTH-1:0]  id_flat_reg;
  logic [CORE_W-1:0]            last_grant_reg;
  logic [CORE_W-1:0]            grant_reg;
  logic [TIMER_W-1:0]           timer_reg;
  logic [ID_WIDTH-1:0]          fproc_id_reg;
  logic                         fproc_req_reg;
  logic [N_CORES-1:0]           core_ready_reg;
  logic [DATA_WIDTH-1:0]        core_data_reg;
  logic                         timeout_err_reg;
  logic                         busy_reg;

  logic [CORE_W-1:0]            grant_next;
  logic                         grant_found;
  logic [CORE_W-1:0]            cand;
  logic [N_CORES-1:0]           grant_onehot;
  logic [N_CORES-1:0]           resp_clear;

  assign grant_onehot = {{(N_CORES-1){1'b0}}, 1'b1} << grant_reg;
  assign resp_clear   = (state_reg == S_RESP) ? grant_onehot : '0;

  // Per-core request latch; a new request in the core's own RESP cycle re-arms it.
  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_core
      logic                pending_bit_reg;
      logic [ID_WIDTH-1:0] id_bit_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          pending_bit_reg <= 1'b0;
          id_bit_reg      <= '0;
        end else if (core_req[gi] && (!pending_bit_reg || resp_clear[gi])) begin
          pending_bit_reg <= 1'b1;
          id_bit_reg      <= core_id[gi*ID_WIDTH +: ID_WIDTH];
        end else if (resp_clear[gi]) begin
          pending_bit_reg <= 1'b0;
        end
      end

      assign pending_reg[gi] = pending_bit_reg;
      assign id_flat_reg[gi*ID_WIDTH +: ID_WIDTH] = id_bit_reg;
    end
  endgenerate

  // First pending core searching cyclically from the one after the last grant.
  always_comb begin
    grant_next  = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      cand = CORE_W'((int'(last_grant_reg) + k) % N_CORES);
      if (!grant_found && pending_reg[cand]) begin
        grant_found = 1'b1;
        grant_next  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      last_grant_reg  <= CORE_W'(N_CORES - 1);
      grant_reg       <= '0;
      timer_reg       <= '0;
      fproc_id_reg    <= '0;
      fproc_req_reg   <= 1'b0;
      core_ready_reg  <= '0;
      core_data_reg   <= '0;
      timeout_err_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_found) begin
            grant_reg     <= grant_next;
            fproc_id_reg  <= id_flat_reg[grant_next*ID_WIDTH +: ID_WIDTH];
            fproc_req_reg <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          fproc_req_reg <= 1'b0;
          timer_reg     <= '0;
          state_reg     <= S_WAIT;
        end
        S_WAIT: begin
          // A real response takes precedence over a simultaneous watchdog expiry.
          if (fproc_ready) begin
            core_data_reg   <= fproc_data;
            core_ready_reg  <= grant_onehot;
            timeout_err_reg <= 1'b0;
            state_reg       <= S_RESP;
          end else if ((TIMEOUT_CYCLES != 0) && (timer_reg == TIMER_LAST)) begin
            core_data_reg   <= '0;
            core_ready_reg  <= grant_onehot;
            timeout_err_reg <= 1'b1;
            state_reg       <= S_RESP;
          end else if (TIMEOUT_CYCLES != 0) begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_RESP: begin
          core_ready_reg  <= '0;
          core_data_reg   <= '0;
          timeout_err_reg <= 1'b0;
          last_grant_reg  <= grant_reg;
          busy_reg        <= 1'b0;
          state_reg       <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign core_ready  = core_ready_reg;
  assign core_data   = core_data_reg;
  assign fproc_req   = fproc_req_reg;
  assign fproc_id    = fproc_id_reg;
  assign fproc_core  = grant_reg;
  assign busy        = busy_reg;
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_fproc_arbiter.sv
// Directed bench for fproc_arbiter: a cycle table for basic and two-core service,
// plus sequences for round-robin, watchdog timeout, coincidence and mid-transaction reset.
module tb_fproc_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  core_req;
  logic [31:0] core_id;
  logic [3:0]  core_ready;
  logic [31:0] core_data;
  logic        fproc_req;
  logic [7:0]  fproc_id;
  logic [1:0]  fproc_core;
  logic        fproc_ready;
  logic [31:0] fproc_data;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  fproc_arbiter #(
    .N_CORES(4), .ID_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_id(core_id),
    .core_ready(core_ready), .core_data(core_data),
    .fproc_req(fproc_req), .fproc_id(fproc_id), .fproc_core(fproc_core),
    .fproc_ready(fproc_ready), .fproc_data(fproc_data),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [31:0] fdata;
    logic        freq;
    logic [7:0]  fid;
    logic        chk_fid;
    logic [1:0]  fcore;
    logic [3:0]  cready;
    logic [31:0] cdata;
    logic        busy;
    logic        terr;
  } vec_t;

  vec_t vecs [17];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    core_req = '0; fproc_ready = 1'b0; fproc_data = '0;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!fproc_req && n < 20) begin
      tick;
      n++;
    end
    chk(name, 32'(fproc_req), 32'd1);
  endtask

  initial begin
    core_id = '0;
    do_reset;

    // Rows: cycle-by-cycle inputs and the outputs expected in that same cycle.
    vecs[0]  = '{4'b0001, 1'b0, 32'h0,         1'b0, 8'h00, 1'b1, 2'd0, 4'b0000, 32'h0,         1'b0, 1'b0};
    vecs[1]  = '{4'b0000, 1'b0, 32'h0,         1'b0, 8'h00, 1'b1, 2'd0, 4'b0000, 32'h0,         1'b0, 1'b0};
    vecs[2]  = '{4'b0000, 1'b0, 32'h0,         1'b1, 8'h2A, 1'b1, 2'd0, 4'b0000, 32'h0,         1'b1, 1'b0};
    vecs[3]  = '{4'b0000, 1'b0, 32'h0,         1'b0, 8'h2A, 1'b1, 2'd0, 4'b0000, 32'h0,         1'b1, 1'b0};
    vecs[4]  = '{4'b0000, 1'b0, 32'h0,         1'b0, 8'h2A, 1'b1, 2'd0, 4'b0000, 32'h0,         1'b1, 1'b0};
    vecs[5]  = '{4'b0000, 1'b1, 32'h1,         1'b0, 8'h2A, 1'b1, 2'd0, 4'b0000, 32'h0,         1'b1, 1'b0};
    vecs[6]  = '{4'b0000, 1'b0, 32'h0,         1'b0, 8'h2A, 1'b1, 2'd0, 4'b0001, 32'h1,         1'b1, 1'b0};
    vecs[7]  = '{4'b1010, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0, 2'd0, 4'b0000, 32'h0,         1'b0, 1'b0};
    vecs[8]  = '{4'b0000, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0, 2'd0, 4'b0000, 32'h0,         1'b0, 1'b0};
    vecs[9]  = '{4'b0000, 1'b0, 32'h0,         1'b1, 8'h11, 1'b1, 2'd1, 4'b0000, 32'h0,         1'b1, 1'b0};
    vecs[10] = '{4'b0000, 1'b1, 32'hAAAA0001,  1'b0, 8'h11, 1'b1, 2'd1, 4'b0000, 32'h0,         1'b1, 1'b0};
    vecs[11] = '{4'b0000, 1'b0, 32'h0,         1'b0, 8'h11, 1'b1, 2'd1, 4'b0010, 32'hAAAA0001,  1'b1, 1'b0};
    vecs[12] = '{4'b0000, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0, 2'd0, 4'b0000, 32'h0,         1'b0, 1'b0};
    vecs[13] = '{4'b0000, 1'b0, 32'h0,         1'b1, 8'h33, 1'b1, 2'd3, 4'b0000, 32'h0,         1'b1, 1'b0};
    vecs[14] = '{4'b0000, 1'b1, 32'hBBBB0003,  1'b0, 8'h33, 1'b1, 2'd3, 4'b0000, 32'h0,         1'b1, 1'b0};
    vecs[15] = '{4'b0000, 1'b0, 32'h0,         1'b0, 8'h33, 1'b1, 2'd3, 4'b1000, 32'hBBBB0003,  1'b1, 1'b0};
    vecs[16] = '{4'b0000, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0, 2'd0, 4'b0000, 32'h0,         1'b0, 1'b0};

    core_id = 32'h3300112A;
    for (int i = 0; i < 17; i++) begin
      core_req    = vecs[i].req;
      fproc_ready = vecs[i].rdy;
      fproc_data  = vecs[i].fdata;
      chk($sformatf("t%0d_fproc_req", i), 32'(fproc_req), 32'(vecs[i].freq));
      chk($sformatf("t%0d_core_ready", i), 32'(core_ready), 32'(vecs[i].cready));
      chk($sformatf("t%0d_core_data", i), core_data, vecs[i].cdata);
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("t%0d_timeout_err", i), 32'(timeout_err), 32'(vecs[i].terr));
      if (vecs[i].chk_fid) begin
        chk($sformatf("t%0d_fproc_id", i), 32'(fproc_id), 32'(vecs[i].fid));
        chk($sformatf("t%0d_fproc_core", i), 32'(fproc_core), 32'(vecs[i].fcore));
      end
      if (|core_ready) $display("table txn: core_ready=%b data=%h", core_ready, core_data);
      tick;
    end
    core_req = '0; fproc_ready = 1'b0; fproc_data = '0;

    // Round-robin: every core keeps re-requesting in its own RESP cycle.
    do_reset;
    begin
      int n_iss, n_resp;
      n_iss = 0; n_resp = 0;
      core_id  = 32'h43424140;
      core_req = 4'hF;
      tick;
      for (int cyc = 0; cyc < 200 && n_resp < 16; cyc++) begin
        core_req    = 4'h0;
        fproc_ready = 1'b0;
        if (fproc_req) begin
          chk("rr_core", 32'(fproc_core), 32'(n_iss % 4));
          chk("rr_id", 32'(fproc_id), 32'(8'h40 + n_iss % 4));
          n_iss++;
        end
        if (dut.state_reg == 2'd2) begin
          fproc_ready = 1'b1;
          fproc_data  = 32'(n_resp + 100);
        end
        if (|core_ready) begin
          chk("rr_ready", 32'(core_ready), 32'(1) << (n_resp % 4));
          chk("rr_data", core_data, 32'(n_resp + 100));
          $display("rr txn %0d: core_ready=%b data=%h", n_resp, core_ready, core_data);
          core_req = core_ready;
          n_resp++;
        end
        tick;
      end
      core_req = '0; fproc_ready = 1'b0;
      chk("rr_count", 32'(n_resp), 32'd16);
    end

    // Watchdog: core0 times out, then core1 is served normally.
    do_reset;
    core_id    = 32'h00007271;
    fproc_data = 32'hDEADBEEF;
    core_req   = 4'b0011;
    tick;
    core_req = '0;
    wait_req("to_issue");
    chk("to_issue_core", 32'(fproc_core), 32'd0);
    begin
      logic early;
      early = 1'b0;
      for (int c = 1; c <= 8; c++) begin
        tick;
        if (|core_ready) early = 1'b1;
      end
      chk("to_no_early_ready", 32'(early), 32'd0);
    end
    tick;
    chk("to_core_ready", 32'(core_ready), 32'b0001);
    chk("to_core_data", core_data, 32'h0);
    chk("to_timeout_err", 32'(timeout_err), 32'd1);
    $display("timeout txn: core_ready=%b data=%h timeout_err=%b", core_ready, core_data, timeout_err);
    tick;
    chk("to_err_pulse", 32'(timeout_err), 32'd0);
    wait_req("to_next_issue");
    chk("to_next_core", 32'(fproc_core), 32'd1);
    chk("to_next_id", 32'(fproc_id), 32'h72);
    tick;
    fproc_ready = 1'b1; fproc_data = 32'h00001234;
    tick;
    fproc_ready = 1'b0;
    chk("to_next_ready", 32'(core_ready), 32'b0010);
    chk("to_next_data", core_data, 32'h00001234);
    chk("to_next_err", 32'(timeout_err), 32'd0);
    $display("post-timeout txn: core_ready=%b data=%h", core_ready, core_data);
    tick;

    // Coincidence: fproc_ready on the watchdog expiry cycle.
    core_id  = 32'h005C0000;
    core_req = 4'b0100;
    tick;
    core_req = '0;
    wait_req("co_issue");
    for (int c = 1; c <= 8; c++) tick;
    fproc_ready = 1'b1; fproc_data = 32'h0000CAFE;
    tick;
    fproc_ready = 1'b0;
    chk("co_core_ready", 32'(core_ready), 32'b0100);
    chk("co_core_data", core_data, 32'h0000CAFE);
    chk("co_timeout_err", 32'(timeout_err), 32'd0);
    $display("coincidence txn: core_ready=%b data=%h timeout_err=%b", core_ready, core_data, timeout_err);
    tick;

    // Reset while waiting on core0 with core2 also pending.
    do_reset;
    core_id  = 32'h000C000A;
    core_req = 4'b0101;
    tick;
    core_req = '0;
    wait_req("rst_issue");
    tick; tick;
    reset = 1'b1;
    tick;
    chk("rst_core_ready", 32'(core_ready), 32'd0);
    chk("rst_core_data", core_data, 32'd0);
    chk("rst_fproc_req", 32'(fproc_req), 32'd0);
    chk("rst_fproc_id", 32'(fproc_id), 32'd0);
    chk("rst_fproc_core", 32'(fproc_core), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    begin
      logic activity;
      activity = 1'b0;
      for (int c = 0; c < 6; c++) begin
        tick;
        if (busy || fproc_req || (|core_ready)) activity = 1'b1;
      end
      chk("rst_pending_cleared", 32'(activity), 32'd0);
    end
    core_id  = 32'h000D000A;
    core_req = 4'b0100;
    tick;
    core_req = '0;
    wait_req("rst_c2_issue");
    chk("rst_c2_core", 32'(fproc_core), 32'd2);
    chk("rst_c2_id", 32'(fproc_id), 32'h0D);
    tick;
    fproc_ready = 1'b1; fproc_data = 32'h00000077;
    tick;
    fproc_ready = 1'b0;
    chk("rst_c2_ready", 32'(core_ready), 32'b0100);
    chk("rst_c2_data", core_data, 32'h00000077);
    $display("post-reset txn: core_ready=%b data=%h", core_ready, core_data);
    begin
      logic again;
      again = 1'b0;
      for (int c = 0; c < 8; c++) begin
        tick;
        if (fproc_req) again = 1'b1;
      end
      chk("rst_core0_not_served", 32'(again), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
